// File: rtl/regfile_pkg.sv
// Shared constants for the register file writeback path.
// Holds the data/address widths, the zero-register index and the err bit positions.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam int ERR_RSV   = 0;
    localparam int ERR_UNRES = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered last-winner pointer.
// Ports: clk, rst (async, active-high), req_a_i/req_b_i requests, gnt_a_o/gnt_b_o grants.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    // last_b_q=1 means B won the last conflict, so A has priority next.
    logic last_b_q;
    logic last_b_d;
    logic conflict;

    assign conflict = req_a_i & req_b_i;
    assign gnt_a_o  = req_a_i & (~req_b_i | last_b_q);
    assign gnt_b_o  = req_b_i & (~req_a_i | ~last_b_q);

    // The pointer moves only when both requesters competed.
    assign last_b_d = conflict ? gnt_b_o : last_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU (A) and load (B) writeback.
// Ports: A/B valid-ready requests, rsv_* reservation, chk_* hazard checks, wf_* write port, pending, err.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_dest,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_dest,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_dest,
    output logic                rsv_ok,
    input  logic [ADDR_W-1:0]   chk_addr_1,
    input  logic [ADDR_W-1:0]   chk_addr_2,
    output logic                chk_busy_1,
    output logic                chk_busy_2,
    output logic                wf_en,
    output logic [ADDR_W-1:0]   wf_dest,
    output logic [DATA_W-1:0]   wf_data,
    output logic [NUM_REGS-1:0] pending,
    output logic [1:0]          err
);

    logic                wf_en_q,   wf_en_d;
    logic [ADDR_W-1:0]   wf_dest_q, wf_dest_d;
    logic [DATA_W-1:0]   wf_data_q, wf_data_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [1:0]          err_q,     err_d;

    logic                hs;
    logic [ADDR_W-1:0]   hs_dest;
    logic [DATA_W-1:0]   hs_data;
    logic                rsv_set;
    logic                rsv_bad;
    logic                unres;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (a_ready),
        .gnt_b_o (b_ready)
    );

    assign hs      = a_ready | b_ready;
    assign hs_dest = a_ready ? a_dest : b_dest;
    assign hs_data = a_ready ? a_data : b_data;

    // A reservation is legal if the register is free or is being committed now.
    assign rsv_ok  = (rsv_dest == REG_ZERO)
                   | ~pending_q[rsv_dest]
                   | (wf_en_q & (wf_dest_q == rsv_dest));
    assign rsv_set = rsv_en & rsv_ok & (rsv_dest != REG_ZERO);
    assign rsv_bad = rsv_en & ~rsv_ok;

    assign unres = hs & (hs_dest != REG_ZERO)
                 & ~pending_q[hs_dest]
                 & ~(rsv_set & (rsv_dest == hs_dest));

    assign chk_busy_1 = pending_q[chk_addr_1] & (chk_addr_1 != REG_ZERO);
    assign chk_busy_2 = pending_q[chk_addr_2] & (chk_addr_2 != REG_ZERO);

    always_comb begin
        wf_en_d   = hs & (hs_dest != REG_ZERO);
        wf_dest_d = hs ? hs_dest : wf_dest_q;
        wf_data_d = hs ? hs_data : wf_data_q;

        // Clear first so a same-edge reservation of the register wins.
        pending_d = pending_q;
        if (wf_en_q) begin
            pending_d[wf_dest_q] = 1'b0;
        end
        if (rsv_set) begin
            pending_d[rsv_dest] = 1'b1;
        end

        err_d            = err_q;
        err_d[ERR_RSV]   = err_q[ERR_RSV] | rsv_bad;
        err_d[ERR_UNRES] = err_q[ERR_UNRES] | unres;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wf_en_q   <= 1'b0;
            wf_dest_q <= '0;
            wf_data_q <= '0;
            pending_q <= '0;
            err_q     <= '0;
        end else begin
            wf_en_q   <= wf_en_d;
            wf_dest_q <= wf_dest_d;
            wf_data_q <= wf_data_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign wf_en   = wf_en_q;
    assign wf_dest = wf_dest_q;
    assign wf_data = wf_data_q;
    assign pending = pending_q;
    assign err     = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed writebacks, reservations and resets.
// Expected writes are queued at handshake and popped by a write-port monitor.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, rsv_en;
    logic [3:0]  a_dest, b_dest, rsv_dest, chk_addr_1, chk_addr_2;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, rsv_ok, chk_busy_1, chk_busy_2;
    logic        wf_en;
    logic [3:0]  wf_dest;
    logic [15:0] wf_data;
    logic [15:0] pending;
    logic [1:0]  err;

    typedef struct packed {
        logic [3:0]  d;
        logic [15:0] v;
    } wr_t;

    wr_t exp_q[$];
    int  ncmp = 0;
    int  nerr = 0;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_dest     (a_dest),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_dest     (b_dest),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .rsv_en     (rsv_en),
        .rsv_dest   (rsv_dest),
        .rsv_ok     (rsv_ok),
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .chk_busy_1 (chk_busy_1),
        .chk_busy_2 (chk_busy_2),
        .wf_en      (wf_en),
        .wf_dest    (wf_dest),
        .wf_data    (wf_data),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [15:0] v);
        wr_t w;
        w.d = d;
        w.v = v;
        exp_q.push_back(w);
    endtask

    // Write-port monitor: every wf_en cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (wf_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL wf_unexpected: got %0h:%0h want none",
                         wf_dest, wf_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wf_dest", 32'(wf_dest), 32'(w.d));
                chk("wf_data", 32'(wf_data), 32'(w.v));
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_valid = 0; b_valid = 0; rsv_en = 0;
        a_dest = 0; b_dest = 0; rsv_dest = 0;
        a_data = 0; b_data = 0;
        chk_addr_1 = 0; chk_addr_2 = 0;
        #12 rst = 1'b0;

        tick; #3;
        chk("rst_wf_en", 32'(wf_en), 32'd0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_err", 32'(err), 32'd0);

        a_valid = 1; a_dest = 0; #3;
        chk("only_a_ar", 32'(a_ready), 32'd1);
        chk("only_a_br", 32'(b_ready), 32'd0);
        tick;
        a_valid = 0; b_valid = 1; b_dest = 0; #3;
        chk("only_b_br", 32'(b_ready), 32'd1);
        chk("only_b_ar", 32'(a_ready), 32'd0);
        tick;
        b_valid = 0;

        rsv_en = 1; rsv_dest = 5; #3;
        chk("rsv5_ok", 32'(rsv_ok), 32'd1);
        tick;
        rsv_en = 0; chk_addr_1 = 5;
        a_valid = 1; a_dest = 5; a_data = 16'h1234; #3;
        chk("busy5_pre", 32'(chk_busy_1), 32'd1);
        chk("a5_ready", 32'(a_ready), 32'd1);
        push(5, 16'h1234);
        tick;
        a_valid = 0; #3;
        chk("wf5_en", 32'(wf_en), 32'd1);
        chk("busy5_wf", 32'(chk_busy_1), 32'd1);
        tick; #3;
        chk("busy5_post", 32'(chk_busy_1), 32'd0);
        chk("pend_after5", 32'(pending), 32'h0);

        rsv_en = 1; rsv_dest = 1;
        tick;
        rsv_dest = 2;
        tick;
        rsv_en = 0;
        a_valid = 1; a_dest = 1; a_data = 16'hA001;
        b_valid = 1; b_dest = 2; b_data = 16'hB002; #3;
        chk("rr1_a", 32'(a_ready), 32'd1);
        chk("rr1_b", 32'(b_ready), 32'd0);
        push(1, 16'hA001);
        tick;
        rsv_en = 1; rsv_dest = 1; #3;
        chk("rr2_b", 32'(b_ready), 32'd1);
        chk("rr2_a", 32'(a_ready), 32'd0);
        chk("rr2_rsv", 32'(rsv_ok), 32'd1);
        push(2, 16'hB002);
        tick;
        rsv_dest = 2; #3;
        chk("rr3_a", 32'(a_ready), 32'd1);
        chk("rr3_rsv", 32'(rsv_ok), 32'd1);
        push(1, 16'hA001);
        tick;
        rsv_en = 0; #3;
        chk("rr4_b", 32'(b_ready), 32'd1);
        chk("rr4_wf_en", 32'(wf_en), 32'd1);
        push(2, 16'hB002);
        tick;
        a_valid = 0; b_valid = 0; #3;
        chk("rr5_wf_en", 32'(wf_en), 32'd1);
        tick; #3;
        chk("rr_pending", 32'(pending), 32'h0);
        chk("rr_err", 32'(err), 32'd0);

        rsv_en = 1; rsv_dest = 3; #3;
        chk("rsv3a_ok", 32'(rsv_ok), 32'd1);
        tick; #3;
        chk("rsv3b_ok", 32'(rsv_ok), 32'd0);
        tick;
        rsv_en = 0; chk_addr_2 = 3; #3;
        chk("rsv3_err", 32'(err), 32'd1);
        chk("rsv3_pend", 32'(pending), 32'h0008);
        chk("busy2_3", 32'(chk_busy_2), 32'd1);
        chk_addr_2 = 0; #1;
        chk("busy2_0", 32'(chk_busy_2), 32'd0);

        rsv_en = 1; rsv_dest = 7;
        tick;
        rsv_en = 0;
        a_valid = 1; a_dest = 7; a_data = 16'h7777; #3;
        chk("a7_ready", 32'(a_ready), 32'd1);
        push(7, 16'h7777);
        tick;
        a_valid = 0; rsv_en = 1; rsv_dest = 7; #3;
        chk("rsv7_wf_dest", 32'(wf_dest), 32'd7);
        chk("rsv7_ok", 32'(rsv_ok), 32'd1);
        tick;
        rsv_en = 0; #3;
        chk("rsv7_pend", 32'(pending), 32'h0088);

        b_valid = 1; b_dest = 0; b_data = 16'hFFFF; #3;
        chk("b0_ready", 32'(b_ready), 32'd1);
        tick;
        b_dest = 9; b_data = 16'h0909; #3;
        chk("b0_no_wf", 32'(wf_en), 32'd0);
        chk("b9_ready", 32'(b_ready), 32'd1);
        push(9, 16'h0909);
        tick;
        b_valid = 0; #3;
        chk("b9_err", 32'(err), 32'd3);

        tick;
        a_valid = 1; a_dest = 3; a_data = 16'h3333; #3;
        push(3, 16'h3333);
        tick;
        a_valid = 0; #1;
        chk("pre_rst_wf", 32'(wf_en), 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_wf", 32'(wf_en), 32'd0);
        chk("mid_rst_pend", 32'(pending), 32'h0);
        chk("mid_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        rst = 1'b0;

        tick;
        tick;
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
